// File: rtl/lcd_bus_ctrl_pkg.sv
// Shared encodings for the HD44780 bus engine: FSM states, init ROM and command constants.
// Also holds the helper that picks the long execution wait for clear/home.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT_LOAD,
    IDLE,
    SETUP,
    EPULSE,
    HOLD,
    EXEC_WAIT
  } lcd_state_e;

  localparam int INIT_LEN = 6;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [6:0] CMD_HOME_MASK = 7'b0000001;
  localparam logic [7:0] FUNCSET       = 8'h38;
  localparam logic [7:0] DISPON        = 8'h0C;
  localparam logic [7:0] ENTRYMODE     = 8'h06;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = FUNCSET;
      3'd3:             init_rom = DISPON;
      3'd4:             init_rom = CMD_CLEAR;
      3'd5:             init_rom = ENTRYMODE;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  // Clear and return-home take far longer inside the LCD than any other command.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] db);
    is_slow_cmd = !rs && ((db == CMD_CLEAR) || (db[7:1] == CMD_HOME_MASK));
  endfunction

  function automatic int max2(input int a, input int b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_ctrl_if.sv
// Byte handshake between the register block (master) and the LCD bus engine (slave).
// A byte transfers on any cycle where wr_valid and wr_ready are both high.
interface lcd_bus_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_bus_ctrl_delay_cnt.sv
// Load/done down-counter: a load of L keeps done low for L-1 cycles, high on the L-th.
// Saturates at zero so it can never wrap.
module lcd_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] value;

  always_ff @(posedge clk) begin
    if (load)
      value <= load_val;
    else if (value != '0)
      value <= value - W'(1);
  end

  assign done = (value <= W'(1));

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 write-only bus engine: autonomous power-up init, then one byte per valid/ready accept.
// Accept at N puts rs/db on the bus at N+1; ready stays low until the byte's execution wait ends.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 4000000,
  parameter int T_SETUP   = 4,
  parameter int T_EPW     = 50,
  parameter int T_HOLD    = 4,
  parameter int T_EXEC    = 4000,
  parameter int T_CLR     = 160000
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  lcd_bus_ctrl_if.slave       wr,
  output logic                init_done,
  output logic                lcd_e,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic [7:0]          lcd_db
);

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EPW, T_HOLD)),
                              max2(T_EXEC, T_CLR));
  localparam int CW    = $clog2(T_MAX + 1);

  lcd_state_e    state;
  logic [2:0]    idx;
  logic          ready_q;
  logic          accept;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_done;

  assign accept      = ready_q && wr.wr_valid;
  assign wr.wr_ready = ready_q;
  assign lcd_rw      = 1'b0;

  // Each timed state loads its own duration on the cycle it is entered.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = CW'(T_POWERUP);
    if (Bus2IP_Reset) begin
      cnt_load = 1'b1;
    end else begin
      case (state)
        INIT_LOAD: begin
          cnt_load = 1'b1;
          cnt_val  = CW'(T_SETUP);
        end
        IDLE: begin
          cnt_load = accept;
          cnt_val  = CW'(T_SETUP);
        end
        SETUP: begin
          cnt_load = cnt_done;
          cnt_val  = CW'(T_EPW);
        end
        EPULSE: begin
          cnt_load = cnt_done;
          cnt_val  = CW'(T_HOLD);
        end
        HOLD: begin
          cnt_load = cnt_done;
          cnt_val  = is_slow_cmd(lcd_rs, lcd_db) ? CW'(T_CLR) : CW'(T_EXEC);
        end
        default: ;
      endcase
    end
  end

  lcd_delay_cnt #(.W(CW)) u_delay (
    .clk      (Bus2IP_Clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state     <= POWERUP;
      idx       <= 3'd0;
      init_done <= 1'b0;
      ready_q   <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
    end else begin
      case (state)
        POWERUP: if (cnt_done) state <= INIT_LOAD;
        INIT_LOAD: begin
          lcd_rs <= 1'b0;
          lcd_db <= init_rom(idx);
          state  <= SETUP;
        end
        IDLE: if (accept) begin
          lcd_rs  <= wr.wr_rs;
          lcd_db  <= wr.wr_data;
          ready_q <= 1'b0;
          state   <= SETUP;
        end
        SETUP: if (cnt_done) begin
          lcd_e <= 1'b1;
          state <= EPULSE;
        end
        EPULSE: if (cnt_done) begin
          lcd_e <= 1'b0;
          state <= HOLD;
        end
        HOLD: if (cnt_done) state <= EXEC_WAIT;
        EXEC_WAIT: if (cnt_done) begin
          if (init_done) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else if (idx == 3'(INIT_LEN - 1)) begin
            init_done <= 1'b1;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= INIT_LOAD;
          end
        end
        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Scoreboard bench for lcd_bus_ctrl: expected {rs,db} bytes are queued at accept time and
// matched against E pulses captured by a bus monitor, together with pulse timing.
module tb_lcd_bus_ctrl;

  localparam int TP = 20, TS = 2, TE = 3, TH = 2, TX = 10, TC = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  always #5 clk = ~clk;

  lcd_bus_ctrl_if wr_if ();

  lcd_bus_ctrl #(
    .T_POWERUP (TP), .T_SETUP (TS), .T_EPW (TE),
    .T_HOLD    (TH), .T_EXEC  (TX), .T_CLR (TC)
  ) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .wr           (wr_if),
    .init_done    (init_done),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_db       (lcd_db)
  );

  typedef struct packed {
    int         rise;
    int         width;
    logic       rs;
    logic [7:0] db;
  } pulse_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records every completed E pulse with its first-high cycle and width.
  logic       e_prev = 1'b0;
  int         cur_rise = 0, cur_w = 0;
  logic       cur_rs = 1'b0;
  logic [7:0] cur_db = 8'h00;
  pulse_t     obs [256];
  int         obs_n = 0;

  always @(negedge clk) begin
    e_prev <= (lcd_e === 1'b1);
    if (lcd_e === 1'b1) begin
      if (!e_prev) begin
        cur_rise <= cyc;
        cur_w    <= 1;
        cur_rs   <= lcd_rs;
        cur_db   <= lcd_db;
      end else begin
        cur_w <= cur_w + 1;
      end
    end else if (e_prev) begin
      obs[obs_n[7:0]] <= '{cur_rise, cur_w, cur_rs, cur_db};
      obs_n           <= obs_n + 1;
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         rd_ptr = 0;
  int         t0 = 0;
  int         t_init_done = 0;
  logic [8:0] exp_q [$];

  task automatic get_pulse(output pulse_t p, output bit ok);
    ok = 1'b0;
    p  = '0;
    for (int i = 0; i < 400; i++) begin
      if (rd_ptr != obs_n) begin
        p  = obs[rd_ptr[7:0]];
        rd_ptr++;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_rs    = 1'b0;
    wr_if.wr_data  = 8'h00;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, wr_if.wr_ready, init_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl e/rs/rw/ready/done: got %b want 00000",
               {lcd_e, lcd_rs, lcd_rw, wr_if.wr_ready, init_done});
    end
    checks++;
    if (lcd_db !== 8'h00) begin
      errors++;
      $display("FAIL reset_db: got %h want 00", lcd_db);
    end
    rst = 1'b0;
    t0  = cyc;
  endtask

  // Powerup 20 cycles (t0..t0+19), INIT_LOAD, two SETUP cycles, so the first E is at t0+23.
  task automatic test_init(input string name);
    logic [7:0] rom [6];
    logic [8:0] e;
    pulse_t     p;
    bit         ok;
    bit         early_rdy;
    int         prev_rise, exp_rise, done_cyc;
    logic [7:0] prev_db;
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, rom[i]});
    prev_rise = 0;
    prev_db   = 8'h00;
    for (int i = 0; i < 6; i++) begin
      get_pulse(p, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s pulse%0d timeout: got none want db %h", name, i, e[7:0]);
        return;
      end
      checks++;
      if ({p.rs, p.db} !== e) begin
        errors++;
        $display("FAIL %s pulse%0d rs/db: got %h want %h", name, i, {p.rs, p.db}, e);
      end
      checks++;
      if (p.width !== TE) begin
        errors++;
        $display("FAIL %s pulse%0d width: got %0d want %0d", name, i, p.width, TE);
      end
      exp_rise = (i == 0) ? t0 + 23 : prev_rise + ((prev_db == 8'h01) ? 38 : 18);
      checks++;
      if (p.rise !== exp_rise) begin
        errors++;
        $display("FAIL %s pulse%0d rise: got %0d want %0d", name, i, p.rise, exp_rise);
      end
      prev_rise = p.rise;
      prev_db   = p.db;
    end
    done_cyc  = -1;
    early_rdy = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (init_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (wr_if.wr_ready !== 1'b0) early_rdy = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (early_rdy) begin
      errors++;
      $display("FAIL %s ready_before_done: got 1 want 0", name);
    end
    checks++;
    if (done_cyc !== prev_rise + 15) begin
      errors++;
      $display("FAIL %s init_done_cycle: got %0d want %0d", name, done_cyc, prev_rise + 15);
    end
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_with_done: got %b want 1", name, wr_if.wr_ready);
    end
    t_init_done = done_cyc;
  endtask

  task automatic test_single_write(input logic rs, input logic [7:0] d, input int ready_dly,
                                   input string name);
    int         n, r;
    pulse_t     p;
    bit         ok;
    logic [8:0] e;
    wr_if.wr_rs    = rs;
    wr_if.wr_data  = d;
    wr_if.wr_valid = 1'b1;
    n = -1;
    for (int k = 0; k < 300; k++) begin
      if (wr_if.wr_ready === 1'b1) begin
        n = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (n < 0) begin
      errors++;
      wr_if.wr_valid = 1'b0;
      $display("FAIL %s accept_timeout: got no ready want ready", name);
      return;
    end
    exp_q.push_back({rs, d});
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    checks++;
    if ({lcd_rs, lcd_db} !== {rs, d}) begin
      errors++;
      $display("FAIL %s bus_at_n+1: got %h want %h", name, {lcd_rs, lcd_db}, {rs, d});
    end
    get_pulse(p, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s pulse_timeout: got none want %h", name, e);
      return;
    end
    checks++;
    if ({p.rs, p.db} !== e) begin
      errors++;
      $display("FAIL %s pulse_rs/db: got %h want %h", name, {p.rs, p.db}, e);
    end
    checks++;
    if (p.rise !== n + 3 || p.width !== TE) begin
      errors++;
      $display("FAIL %s pulse_timing: got rise %0d width %0d want rise %0d width %0d",
               name, p.rise, p.width, n + 3, TE);
    end
    r = -1;
    for (int k = 0; k < 300; k++) begin
      if (wr_if.wr_ready === 1'b1) begin
        r = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (r !== n + ready_dly) begin
      errors++;
      $display("FAIL %s ready_again: got %0d want %0d", name, r, n + ready_dly);
    end
  endtask

  task automatic test_data_write();
    test_single_write(1'b1, 8'h41, 18, "data_41");
  endtask

  task automatic test_clear_vs_data();
    test_single_write(1'b0, 8'h01, 38, "clear");
    test_single_write(1'b0, 8'h02, 38, "home_02");
    test_single_write(1'b0, 8'h03, 38, "home_03");
    test_single_write(1'b1, 8'h01, 18, "data_01");
    test_single_write(1'b0, 8'h0C, 18, "cmd_0c");
  endtask

  task automatic test_streaming();
    logic [7:0] bytes [3];
    int         n [3];
    int         r;
    pulse_t     p;
    bit         ok;
    logic [8:0] e;
    bytes          = '{8'h48, 8'h49, 8'h21};
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = bytes[0];
    wr_if.wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n[k] = -1;
      for (int j = 0; j < 300; j++) begin
        if (wr_if.wr_ready === 1'b1) begin
          n[k] = cyc;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (n[k] < 0) begin
        errors++;
        wr_if.wr_valid = 1'b0;
        $display("FAIL stream accept%0d_timeout: got no ready want ready", k);
        return;
      end
      exp_q.push_back({1'b1, bytes[k]});
      @(negedge clk);
      if (k < 2) wr_if.wr_data = bytes[k + 1];
      else       wr_if.wr_valid = 1'b0;
    end
    checks++;
    if (n[1] - n[0] !== 18 || n[2] - n[1] !== 18) begin
      errors++;
      $display("FAIL stream accept_spacing: got %0d,%0d want 18,18", n[1] - n[0], n[2] - n[1]);
    end
    for (int k = 0; k < 3; k++) begin
      get_pulse(p, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {p.rs, p.db} !== e || p.rise !== n[k] + 3) begin
        errors++;
        $display("FAIL stream pulse%0d: got ok %0d db %h rise %0d want db %h rise %0d",
                 k, ok, {p.rs, p.db}, p.rise, e, n[k] + 3);
      end
    end
    r = -1;
    for (int j = 0; j < 300; j++) begin
      if (wr_if.wr_ready === 1'b1) begin
        r = cyc;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (r !== n[2] + 18 || rd_ptr != obs_n) begin
      errors++;
      $display("FAIL stream tail: got ready %0d extra pulses %0d want ready %0d extra 0",
               r, obs_n - rd_ptr, n[2] + 18);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int seen;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h55;
    wr_if.wr_valid = 1'b1;
    seen = 0;
    for (int j = 0; j < 300; j++) begin
      if (wr_if.wr_ready === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    for (int j = 0; j < 50; j++) begin
      if (lcd_e === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL midreset no_epulse: got e=0 want e=1");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_e !== 1'b0) begin
      errors++;
      $display("FAIL midreset lcd_e: got %b want 0", lcd_e);
    end
    checks++;
    if ({lcd_rs, lcd_rw, wr_if.wr_ready, init_done, lcd_db} !== 12'h000) begin
      errors++;
      $display("FAIL midreset outputs rs/rw/ready/done/db: got %h want 000",
               {lcd_rs, lcd_rw, wr_if.wr_ready, init_done, lcd_db});
    end
    // Hold a byte pending across reset and init; it must wait for init_done.
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h5A;
    wr_if.wr_valid = 1'b1;
    repeat (2) @(negedge clk);
    rd_ptr = obs_n;
    rst    = 1'b0;
    t0     = cyc;
  endtask

  task automatic test_early_valid();
    pulse_t     p;
    bit         ok;
    logic [8:0] e;
    checks++;
    if (wr_if.wr_valid !== 1'b1 || wr_if.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_valid handshake: got valid %b ready %b want 1 1",
               wr_if.wr_valid, wr_if.wr_ready);
    end
    exp_q.push_back({1'b1, 8'h5A});
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    checks++;
    if ({lcd_rs, lcd_db} !== 9'h15A) begin
      errors++;
      $display("FAIL early_valid bus: got %h want 15a", {lcd_rs, lcd_db});
    end
    get_pulse(p, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {p.rs, p.db} !== e || p.rise !== t_init_done + 3) begin
      errors++;
      $display("FAIL early_valid pulse: got ok %0d db %h rise %0d want db %h rise %0d",
               ok, {p.rs, p.db}, p.rise, e, t_init_done + 3);
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_data_write();
    test_clear_vs_data();
    test_streaming();
    test_reset_mid_pulse();
    test_init("reinit");
    test_early_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_bus_ctrl.md
Name: lcd_bus_ctrl

Overview:
- HD44780-compatible character-LCD bus timing engine.
- Sits directly downstream of the LCD peripheral's IPIF user-logic register block and consumes the command/data bytes that block latches from bus writes.
- After reset it runs the power-up/init sequence autonomously.
- It then accepts one byte at a time over a valid/ready handshake and drives E/RS/RW/DB with parameterised setup, pulse, hold and execution delays.
- Write-only: no busy-flag readback.

Parameters:
- T_POWERUP, 4000000, cycles to wait after reset before the first init command (40 ms at 100 MHz).
- T_SETUP, 4, cycles RS/DB are stable before E rises (min 1).
- T_EPW, 50, cycles E is held high (min 1).
- T_HOLD, 4, cycles RS/DB are held after E falls (min 1).
- T_EXEC, 4000, execution wait after a normal command or data write.
- T_CLR, 160000, execution wait after a clear or home command.

Ports:
- Bus2IP_Clk  in  1  clock; the only clock.
- Bus2IP_Reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  byte available from the register block.
- wr_ready  out  1  controller can accept a byte this cycle.
- wr_rs  in  1  register select (0 = command, 1 = data).
- wr_data  in  8  byte to write.
- init_done  out  1  init sequence complete; stays high until reset.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; constant 0.
- lcd_db  out  8  LCD data bus.

Behaviour:
- Reset: synchronous and active-high, sampled on Bus2IP_Clk. All outputs are 0 while Bus2IP_Reset is high: lcd_e, lcd_rs, lcd_rw, lcd_db, wr_ready, init_done. The FSM enters POWERUP and the delay counter loads T_POWERUP.
- Reset mid-operation: lcd_e is 0 the cycle after reset is sampled. Any in-flight byte is dropped and the full init sequence reruns.
- FSM states: POWERUP, INIT_LOAD, IDLE, SETUP, EPULSE, HOLD, EXEC_WAIT.
- POWERUP: count T_POWERUP cycles, then go to INIT_LOAD.
- Init ROM: 6 entries, all rs=0, in order 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. INIT_LOAD drives the next ROM entry onto lcd_rs/lcd_db and goes to SETUP, with an index counter of 0..5.
- IDLE: wr_ready=1 only here and only when init_done=1. An accept occurs in cycle N when wr_valid && wr_ready. In that cycle wr_rs and wr_data are captured; at N+1 they appear on lcd_rs/lcd_db and the FSM enters SETUP.
- SETUP: T_SETUP cycles with e=0, then EPULSE.
- EPULSE: lcd_e=1 for exactly T_EPW cycles, then HOLD.
- HOLD: e=0 for T_HOLD cycles, rs/db unchanged, then EXEC_WAIT.
- EXEC_WAIT: rs/db keep their last values. The wait is T_CLR if rs=0 and (db==0x01 or db[7:1]==7'b0000001); otherwise it is T_EXEC. rs=1 bytes always use T_EXEC.
- After EXEC_WAIT:
  - During init: go to INIT_LOAD, or set init_done and go to IDLE after entry 5.
  - Otherwise: go to IDLE.
- Latency: for an accept at N, lcd_e is high during cycles N+1+T_SETUP .. N+T_SETUP+T_EPW. wr_ready is next high at cycle N+1+T_SETUP+T_EPW+T_HOLD+Twait.
- Back-to-back transfers: a wr_valid held high is accepted on the first ready cycle. Exactly one byte is accepted per ready-high cycle; no byte is duplicated or dropped.
- Valid during init or busy: ignored, because ready is low. The upstream block must hold the byte.
- Delay counter: width is clog2 of the largest parameter. It is a down-counter loaded on state entry; it cannot wrap or underflow, and a load value of 1 means one cycle.

Decomposition:
- Shared package lcd_pkg holds:
  - FSM state encodings.
  - Init ROM contents and length (6).
  - Command constants: CMD_CLEAR=0x01, CMD_HOME_MASK=7'b0000001, FUNCSET=0x38, DISPON=0x0C, ENTRYMODE=0x06.
- One sub-module, lcd_delay_cnt: load/value/done down-counter, parameterised by width.

Test Plan:
Bench parameters are T_POWERUP=20, T_SETUP=2, T_EPW=3, T_HOLD=2, T_EXEC=10, T_CLR=30.
- Init sequence: release reset at cycle 0 → no E pulse before cycle 20. Then 6 E pulses, each 3 cycles wide, with db 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and rs=0. The gap after 0x01 uses the 30-cycle wait. init_done and wr_ready then rise together.
- Data write: accept rs=1, data 0x41 at N → lcd_rs=1 and db=0x41 from N+1; e high N+3..N+5; wr_ready high again at N+18.
- Clear vs data 0x01: rs=0, 0x01 at N → ready again at N+38. rs=0, 0x02 (home) → ready again at N+38. rs=1, 0x01 → ready again at N+18.
- Streaming: wr_valid held high with 3 bytes 0x48, 0x49, 0x21 (rs=1) → accepts exactly 18 cycles apart; three E pulses with matching db; no duplicates.
- Early valid: wr_valid=1 asserted during init → no accept while init_done=0; the byte is accepted in the first cycle after init_done rises.
- Reset mid-pulse: assert reset during EPULSE → lcd_e=0 the next cycle, all outputs 0, init_done=0; the init sequence restarts from POWERUP.
